dm_wb_cache: RTL and testbench

- Parametrised direct-mapped, write-back, write-allocate data cache between one core's data port and the shared RAM port.
- Replaces the fixed 256x16-word cache with a cycle-accurate FSM. It evicts dirty lines before refill, has a real RAM handshake (no wait statements), and supports an explicit flush of all dirty lines with a done pulse.

---
 rtl/dm_wb_cache.sv | 204 ++++++++++++++++++++
 tb/tb_dm_wb_cache.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_wb_cache.sv
// Direct-mapped, write-back, write-allocate data cache between a core's data
// port and a shared word-addressed RAM. Dirty victims are written back before
// refill; a flush request writes back every dirty line and pulses flush_done.
module dm_wb_cache #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 16,
  parameter int SETS       = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data_w,
  input  logic              cpu_read,
  input  logic              cpu_write,
  output logic              cpu_wait,
  output logic [DATA_W-1:0] cpu_data_r,
  input  logic              flush,
  output logic              flush_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_w,
  output logic              ram_read,
  output logic              ram_write,
  input  logic              ram_wait,
  input  logic [DATA_W-1:0] ram_data_r
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [1:0] {IDLE, WB, FILL, FLUSH_SCAN} state_t;

  state_t state, state_d;

  // line storage
  logic [SETS-1:0]   valid;
  logic [SETS-1:0]   dirty;
  logic [TAG_W-1:0]  tag_arr  [SETS];
  logic [DATA_W-1:0] data_arr [SETS*LINE_WORDS];

  // request decode: tag | index | offset
  logic [TAG_W-1:0] cpu_tag;
  logic [IDX_W-1:0] cpu_idx;
  logic [OFF_W-1:0] cpu_off;

  // burst bookkeeping
  logic [IDX_W-1:0] cur_idx;
  logic [TAG_W-1:0] new_tag;
  logic [OFF_W-1:0] cnt;
  logic [OFF_W-1:0] cnt_nx;
  logic [IDX_W-1:0] scnt;
  logic             flush_pending;
  logic             in_flush;

  logic hit;
  logic req;
  logic cpu_ready;
  logic accept_write;
  logic wb_xfer;
  logic fill_xfer;
  logic last_word;
  logic last_set;

  assign cpu_tag = cpu_addr[ADDR_W-1 -: TAG_W];
  assign cpu_idx = cpu_addr[OFF_W +: IDX_W];
  assign cpu_off = cpu_addr[OFF_W-1:0];

  assign hit          = valid[cpu_idx] && (tag_arr[cpu_idx] == cpu_tag);
  assign req          = cpu_read | cpu_write;
  assign cpu_ready    = (state == IDLE) && hit && !flush_pending;
  assign cpu_wait     = req && !cpu_ready;
  assign cpu_data_r   = data_arr[{cpu_idx, cpu_off}];
  assign accept_write = cpu_write && cpu_ready;

  assign wb_xfer   = (state == WB)   && ram_write && !ram_wait;
  assign fill_xfer = (state == FILL) && ram_read  && !ram_wait;
  assign last_word = &cnt;
  assign last_set  = &scnt;
  assign cnt_nx    = cnt + OFF_W'(1);

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // next-state selection
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (flush_pending)    state_d = FLUSH_SCAN;
        else if (req && !hit) state_d = dirty[cpu_idx] ? WB : FILL;
      end
      WB:         if (wb_xfer && last_word) state_d = in_flush ? FLUSH_SCAN : FILL;
      FILL:       if (fill_xfer && last_word) state_d = IDLE;
      FLUSH_SCAN: begin
        if (dirty[scnt])   state_d = WB;
        else if (last_set) state_d = IDLE;
      end
      default:    state_d = IDLE;
    endcase
  end

  // data and tag arrays: CPU write hits and refill words; never reset
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (accept_write) data_arr[{cpu_idx, cpu_off}] <= cpu_data_w;
      if (fill_xfer) begin
        data_arr[{cur_idx, cnt}] <= ram_data_r;
        if (last_word) tag_arr[cur_idx] <= new_tag;
      end
    end
  end

  // line status, counters, flush tracking and registered RAM strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid         <= '0;
      dirty         <= '0;
      ram_read      <= 1'b0;
      ram_write     <= 1'b0;
      ram_addr      <= '0;
      ram_data_w    <= '0;
      flush_done    <= 1'b0;
      cnt           <= '0;
      scnt          <= '0;
      cur_idx       <= '0;
      new_tag       <= '0;
      flush_pending <= 1'b0;
      in_flush      <= 1'b0;
    end else begin
      flush_done    <= 1'b0;
      flush_pending <= flush_pending | flush;
      unique case (state)
        IDLE: begin
          cur_idx <= cpu_idx;
          new_tag <= cpu_tag;
          cnt     <= '0;
          if (accept_write) dirty[cpu_idx] <= 1'b1;
          if (flush_pending) begin
            in_flush <= 1'b1;
            scnt     <= '0;
          end
        end
        // First cycle raises the strobe for word 0; each transfer then
        // presents the following word so the RAM sees a gapless burst.
        WB: begin
          if (!ram_write) begin
            ram_write  <= 1'b1;
            ram_addr   <= {tag_arr[cur_idx], cur_idx, cnt};
            ram_data_w <= data_arr[{cur_idx, cnt}];
          end else if (!ram_wait) begin
            if (last_word) begin
              ram_write        <= 1'b0;
              dirty[cur_idx]   <= 1'b0;
              valid[cur_idx]   <= 1'b0;
              cnt              <= '0;
            end else begin
              cnt        <= cnt_nx;
              ram_addr   <= {tag_arr[cur_idx], cur_idx, cnt_nx};
              ram_data_w <= data_arr[{cur_idx, cnt_nx}];
            end
          end
        end
        FILL: begin
          if (!ram_read) begin
            ram_read <= 1'b1;
            ram_addr <= {new_tag, cur_idx, cnt};
          end else if (!ram_wait) begin
            if (last_word) begin
              ram_read       <= 1'b0;
              valid[cur_idx] <= 1'b1;
              dirty[cur_idx] <= 1'b0;
              cnt            <= '0;
            end else begin
              cnt      <= cnt_nx;
              ram_addr <= {new_tag, cur_idx, cnt_nx};
            end
          end
        end
        // A dirty set is revisited after its write-back and then found clean,
        // so the set counter only advances past clean sets.
        FLUSH_SCAN: begin
          cur_idx <= scnt;
          cnt     <= '0;
          if (!dirty[scnt]) begin
            if (last_set) begin
              flush_done    <= 1'b1;
              flush_pending <= 1'b0;
              in_flush      <= 1'b0;
              scnt          <= '0;
            end else begin
              scnt <= scnt + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_wb_cache.sv
// Scoreboard bench for dm_wb_cache: the reference is a flat word memory that
// every CPU write updates; reads push their expected word into a queue that a
// monitor pops when the cache presents read data. A RAM responder models the
// shared memory with programmable stalls.
module tb_dm_wb_cache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_data_w;
  logic        cpu_read;
  logic        cpu_write;
  logic        cpu_wait;
  logic [31:0] cpu_data_r;
  logic        flush;
  logic        flush_done;
  logic [31:0] ram_addr;
  logic [31:0] ram_data_w;
  logic        ram_read;
  logic        ram_write;
  logic        ram_wait = 1'b0;
  logic [31:0] ram_data_r = '0;

  dm_wb_cache #(.DATA_W(32), .ADDR_W(32), .LINE_WORDS(16), .SETS(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_data_w(cpu_data_w), .cpu_read(cpu_read),
    .cpu_write(cpu_write), .cpu_wait(cpu_wait), .cpu_data_r(cpu_data_r),
    .flush(flush), .flush_done(flush_done),
    .ram_addr(ram_addr), .ram_data_w(ram_data_w), .ram_read(ram_read),
    .ram_write(ram_write), .ram_wait(ram_wait), .ram_data_r(ram_data_r)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_ref [logic [31:0]];
  logic [31:0] ram_mem [logic [31:0]];
  logic [31:0] exp_q [$];
  logic [31:0] rd_log [$];
  logic [31:0] wr_log [$];

  int stall_mode = 0;
  int sc = 0;
  int rd_cycles = 0;
  int stall_cycles = 0;
  int done_cnt = 0;
  int cyc = 0;
  int done_cyc = 32'h7fff_ffff;
  int acc_cyc = 0;
  bit prev_stall = 1'b0;
  logic p_rd, p_wr;
  logic [31:0] p_addr, p_dw;

  // Initial RAM image: line 0x1000 holds 0xA000_0000+k, everything else a hash.
  function automatic logic [31:0] ram_init(input logic [31:0] a);
    if (a[31:4] == 28'h100) return 32'hA000_0000 + {28'h0, a[3:0]};
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : ram_init(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return mem_ref.exists(a) ? mem_ref[a] : ram_init(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RAM side: commit transfers at the edge and log them
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (ram_read) rd_cycles++;
      if ((ram_read | ram_write) && ram_wait) stall_cycles++;
      if (ram_read && !ram_wait) rd_log.push_back(ram_addr);
      if (ram_write && !ram_wait) begin
        wr_log.push_back(ram_addr);
        ram_mem[ram_addr] = ram_data_w;
      end
    end
  end

  // RAM stall generation, protocol checks and the read-data monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        chk("stall_read_stable",  32'(ram_read),  32'(p_rd));
        chk("stall_write_stable", 32'(ram_write), 32'(p_wr));
        chk("stall_addr_stable",  ram_addr, p_addr);
        if (ram_write) chk("stall_wdata_stable", ram_data_w, p_dw);
      end
      if (ram_read | ram_write) chk("strobe_exclusive", 32'(ram_read & ram_write), 32'd0);
    end
    if (ram_read | ram_write) begin
      case (stall_mode)
        1: begin
          if (sc < 3) begin ram_wait = 1'b1; sc++; end
          else begin ram_wait = 1'b0; sc = 0; end
        end
        2:       ram_wait = ($urandom_range(0, 3) == 0);
        default: ram_wait = 1'b0;
      endcase
    end else begin
      ram_wait = 1'b0;
      sc = 0;
    end
    ram_data_r = ram_rd(ram_addr);
    prev_stall = rst_n && (ram_read | ram_write) && ram_wait;
    p_rd = ram_read; p_wr = ram_write; p_addr = ram_addr; p_dw = ram_data_w;
    if (flush_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rst_n && cpu_read && !cpu_write && !cpu_wait) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_unexpected: got %h at addr %h, required no read", cpu_data_r, cpu_addr);
      end else begin
        chk("read_data", cpu_data_r, exp_q.pop_front());
      end
    end
  end

  task automatic cpu_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, output int waits);
    @(posedge clk); #1;
    cpu_addr = addr; cpu_data_w = wdata; cpu_read = rd; cpu_write = wr;
    if (wr)      mem_ref[addr] = wdata;
    else if (rd) exp_q.push_back(ref_rd(addr));
    waits = 0;
    forever begin
      @(negedge clk);
      if (!cpu_wait) break;
      waits++;
      if (waits > 3000) begin
        checks++;
        errors++;
        $display("FAIL req_timeout: addr %h waited %0d cycles, required acceptance", addr, waits);
        break;
      end
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
  endtask

  task automatic clear_logs();
    rd_log.delete();
    wr_log.delete();
  endtask

  task automatic chk_burst(input string name, input logic [31:0] base, input int is_read);
    int n;
    n = is_read ? rd_log.size() : wr_log.size();
    chk({name, "_count"}, 32'(n), 32'd16);
    for (int k = 0; k < 16 && k < n; k++)
      chk({name, "_addr"}, is_read ? rd_log[k] : wr_log[k], base + 32'(k));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, w2, start;
    int unsigned tags [5] = '{1, 2, 3, 4, 9};
    int unsigned idxs [4] = '{0, 1, 2, 255};
    rst_n = 1'b0; cpu_addr = '0; cpu_data_w = '0; cpu_read = 1'b0; cpu_write = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_read",   32'(ram_read),   32'd0);
    chk("rst_ram_write",  32'(ram_write),  32'd0);
    chk("rst_ram_addr",   ram_addr,        32'd0);
    chk("rst_ram_data_w", ram_data_w,      32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    chk("rst_cpu_wait",   32'(cpu_wait),   32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // clean miss then hit
    clear_logs();
    cpu_req(1'b1, 1'b0, 32'h1003, 32'h0, w);
    chk("clean_miss_waits", 32'(w), 32'd18);
    chk_burst("clean_fill", 32'h1000, 1);
    chk("clean_miss_no_wb", 32'(wr_log.size()), 32'd0);
    cpu_req(1'b1, 1'b0, 32'h1005, 32'h0, w);
    chk("read_hit_waits", 32'(w), 32'd0);

    // write hit, then dirty conflict miss
    clear_logs();
    cpu_req(1'b0, 1'b1, 32'h1002, 32'hDEAD_BEEF, w);
    chk("write_hit_waits", 32'(w), 32'd0);
    chk("write_hit_traffic", 32'(rd_log.size() + wr_log.size()), 32'd0);
    cpu_req(1'b1, 1'b0, 32'h41002, 32'h0, w);
    chk("dirty_miss_waits", 32'(w), 32'd35);
    chk_burst("victim_wb", 32'h1000, 0);
    chk("victim_word2", ram_rd(32'h1002), 32'hDEAD_BEEF);
    chk_burst("dirty_fill", 32'h41000, 1);

    // three stall cycles per word during a clean fill
    stall_mode = 1; rd_cycles = 0; stall_cycles = 0;
    clear_logs();
    cpu_req(1'b1, 1'b0, 32'h2007, 32'h0, w);
    stall_mode = 0;
    chk("stall_miss_waits", 32'(w), 32'd66);
    chk("stall_read_cycles", 32'(rd_cycles), 32'd64);
    chk("stall_cycles", 32'(stall_cycles), 32'd48);
    chk_burst("stall_fill", 32'h2000, 1);

    // flush of dirty sets 0 and 255 with a CPU read issued mid-flush
    cpu_req(1'b0, 1'b1, 32'h2000, 32'hC0FF_EE01, w);
    cpu_req(1'b0, 1'b1, 32'h30FF5, 32'hC0FF_EE02, w);
    cpu_req(1'b1, 1'b0, 32'h5010, 32'h0, w);
    clear_logs();
    done_cnt = 0; done_cyc = 32'h7fff_ffff;
    fork
      pulse_flush();
      begin
        repeat (4) @(posedge clk);
        cpu_req(1'b1, 1'b0, 32'h5010, 32'h0, w2);
      end
    join
    repeat (5) @(posedge clk);
    chk("flush_done_pulses", 32'(done_cnt), 32'd1);
    chk("flush_read_after_done", 32'(acc_cyc >= done_cyc), 32'd1);
    chk("flush_wb_count", 32'(wr_log.size()), 32'd32);
    for (int k = 0; k < 32 && k < wr_log.size(); k++)
      chk("flush_wb_addr", wr_log[k], (k < 16) ? 32'h2000 + 32'(k) : 32'h30FF0 + 32'(k - 16));
    chk("flush_clean_kept", 32'(rd_log.size()), 32'd0);
    chk("flush_word_set0",   ram_rd(32'h2000),  32'hC0FF_EE01);
    chk("flush_word_set255", ram_rd(32'h30FF5), 32'hC0FF_EE02);

    // reset during a fill after seven words
    clear_logs();
    fork
      cpu_req(1'b1, 1'b0, 32'h7003, 32'h0, w);
      begin
        int n = 0;
        while (rd_log.size() < 7 && n < 200) begin @(negedge clk); n++; end
        chk("mid_fill_reached", 32'(rd_log.size()), 32'd7);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_ram_read", 32'(ram_read), 32'd0);
        chk("mid_rst_ram_addr", ram_addr, 32'd0);
        rd_log.delete();
        @(posedge clk); #1 rst_n = 1'b1;
      end
    join
    chk_burst("refill_after_rst", 32'h7000, 1);

    // read and write together on a hit
    clear_logs();
    cpu_req(1'b1, 1'b1, 32'h7004, 32'h1234_5678, w);
    chk("rw_hit_waits", 32'(w), 32'd0);
    chk("rw_hit_traffic", 32'(rd_log.size() + wr_log.size()), 32'd0);
    cpu_req(1'b1, 1'b0, 32'h8000, 32'h0, w);
    chk("rw_dirty_miss_waits", 32'(w), 32'd35);
    chk_burst("rw_victim_wb", 32'h7000, 0);
    chk("rw_written_word", ram_rd(32'h7004), 32'h1234_5678);

    // randomized traffic over a few conflicting sets with random stalls
    stall_mode = 2;
    for (int i = 0; i < 300; i++) begin
      int kind;
      logic [31:0] a;
      a = (32'(tags[$urandom_range(0, 4)]) << 12) | (32'(idxs[$urandom_range(0, 3)]) << 4)
          | 32'($urandom_range(0, 15));
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 29) == 0) pulse_flush();
      if (kind < 5)      cpu_req(1'b1, 1'b0, a, 32'h0, w);
      else if (kind < 9) cpu_req(1'b0, 1'b1, a, $urandom, w);
      else               cpu_req(1'b1, 1'b1, a, $urandom, w);
    end
    repeat (3) @(posedge clk);
    start = done_cnt;
    pulse_flush();
    w = 0;
    while (done_cnt == start && w < 5000) begin @(negedge clk); w++; end
    chk("final_flush_done", 32'(done_cnt - start), 32'd1);
    foreach (mem_ref[a]) chk("final_ram_contents", ram_rd(a), mem_ref[a]);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
